// File: rtl/btn_ctrl_pkg.sv
// Shared types and defaults for the button repeat controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } owner_e;

  localparam int DEF_TICK_DIV = 12000;  // 1 ms at 12 MHz
  localparam int DEF_DELAY_T  = 500;
  localparam int DEF_RATE_T   = 100;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timebase prescaler: pulses tick for one cycle every DIV clocks.
// Latency: first tick DIV cycles after restart is released (tick while count == DIV-1).
// Backpressure: none; restart has priority and zeroes the count synchronously.
//
// Ports: clk, clr_n (async active-low), restart (sync zero), tick (1-cycle pulse).
module tick_gen
  import btn_ctrl_pkg::*;
#(
  parameter int DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);

  localparam int            W    = clog2_min1(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/btn_repeat_ctrl.sv
// Button controller: turns up/dn/clr levels into 1-cycle command ticks with hold-to-repeat.
// Latency: level sampled at edge k gives its tick after edge k+1; release acts at its own sample edge.
// Backpressure: none; ticks are fire-and-forget, non-owner/lower-priority edges are dropped.
//
// Ports: clk, clr_n (async active-low); up_lvl/dn_lvl/clr_lvl debounced levels in;
//        up_tick/dn_tick/clr_tick one-cycle commands, repeating, busy (all registered) out.
module btn_repeat_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DELAY_T  = DEF_DELAY_T,
  parameter int RATE_T   = DEF_RATE_T
) (
  input  logic clk,
  input  logic clr_n,
  input  logic up_lvl,
  input  logic dn_lvl,
  input  logic clr_lvl,
  output logic up_tick,
  output logic dn_tick,
  output logic clr_tick,
  output logic repeating,
  output logic busy
);

  localparam int             MAX_T     = (DELAY_T > RATE_T) ? DELAY_T : RATE_T;
  localparam int             CW        = clog2_min1(MAX_T + 1);
  localparam logic [CW-1:0]  DLY_LAST  = CW'(DELAY_T - 1);
  localparam logic [CW-1:0]  RATE_LAST = CW'(RATE_T - 1);

  // Bit order for the sampled levels: [2]=clr, [1]=dn, [0]=up.
  logic [2:0]    samp_q, samp_d;
  logic [2:0]    prev_q, prev_d;
  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          up_tick_q, up_tick_d;
  logic          dn_tick_q, dn_tick_d;
  logic          clr_tick_q, clr_tick_d;
  logic          busy_q, busy_d;
  logic          rep_q, rep_d;

  logic          tb_restart;
  logic          tb_tick;
  logic [2:0]    rise;
  logic          own_lvl;
  logic [CW-1:0] own_last;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (tb_restart),
    .tick    (tb_tick)
  );

  // Edges come from the registered samples; prev starts at 1 so a button
  // held through reset never looks like a fresh press.
  assign rise = samp_q & ~prev_q;

  // Release looks at the live level so a repeat due on the release edge is lost.
  assign own_lvl  = (owner_q == UP) ? up_lvl : dn_lvl;
  assign own_last = (state_q == DELAY) ? DLY_LAST : RATE_LAST;

  always_comb begin
    samp_d     = {clr_lvl, dn_lvl, up_lvl};
    prev_d     = samp_q;
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    up_tick_d  = 1'b0;
    dn_tick_d  = 1'b0;
    clr_tick_d = 1'b0;
    tb_restart = 1'b0;

    case (state_q)
      IDLE: begin
        // Hold the timebase at zero so the hold interval starts exactly at the press.
        tb_restart = 1'b1;
        cnt_d      = '0;
        if (rise[2]) begin
          clr_tick_d = 1'b1;
        end else if (rise[0]) begin
          up_tick_d = 1'b1;
          owner_d   = UP;
          state_d   = DELAY;
        end else if (rise[1]) begin
          dn_tick_d = 1'b1;
          owner_d   = DN;
          state_d   = DELAY;
        end
      end

      DELAY, REPEAT: begin
        if (!own_lvl) begin
          state_d = IDLE;
        end else if (rise[2]) begin
          clr_tick_d = 1'b1;
          state_d    = IDLE;
        end else if (tb_tick) begin
          if (cnt_q == own_last) begin
            cnt_d = '0;
            if (owner_q == UP) begin
              up_tick_d = 1'b1;
            end else begin
              dn_tick_d = 1'b1;
            end
            if (state_q == DELAY) begin
              state_d    = REPEAT;
              tb_restart = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    rep_d  = (state_d == REPEAT);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      samp_q     <= '1;
      prev_q     <= '1;
      state_q    <= IDLE;
      owner_q    <= UP;
      cnt_q      <= '0;
      up_tick_q  <= 1'b0;
      dn_tick_q  <= 1'b0;
      clr_tick_q <= 1'b0;
      busy_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      samp_q     <= samp_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      up_tick_q  <= up_tick_d;
      dn_tick_q  <= dn_tick_d;
      clr_tick_q <= clr_tick_d;
      busy_q     <= busy_d;
      rep_q      <= rep_d;
    end
  end

  assign up_tick   = up_tick_q;
  assign dn_tick   = dn_tick_q;
  assign clr_tick  = clr_tick_q;
  assign busy      = busy_q;
  assign repeating = rep_q;

endmodule
